aabb_overlap_test: RTL and testbench

Consumer of box AABB results: accepts two axis-aligned bounding boxes (six IEEE-754 single-precision bounds each, ordered min/max per axis x, y, z), tests them for overlap axis by axis, and returns an overlap flag plus the first separating axis. Sits directly downstream of the AABB compute blocks, forming the broadphase stage that selects candidate geometry pairs for narrowphase collision. Uses the same stb/ack handshake as the float arithmetic units.

---
 rtl/aabb_pkg.sv | 27 ++
 rtl/aabb_overlap_test_if.sv | 20 ++
 rtl/aabb_overlap_test_float_le.sv | 29 ++
 rtl/aabb_overlap_test.sv | 86 ++++++++
 tb/tb_aabb_overlap_test.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aabb_pkg.sv
// Shared constants and types for the AABB broadphase overlap block.
package aabb_pkg;
    localparam int FLOAT_W    = 32;
    localparam int NUM_BOUNDS = 6;
    localparam logic [7:0] FLT_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        AXIS_NONE = 2'd0,
        AXIS_X    = 2'd1,
        AXIS_Y    = 2'd2,
        AXIS_Z    = 2'd3
    } axis_e;

    // Bound slots within a box: min/max per axis in x, y, z order.
    localparam logic [2:0] XMIN = 3'd0;
    localparam logic [2:0] XMAX = 3'd1;
    localparam logic [2:0] YMIN = 3'd2;
    localparam logic [2:0] YMAX = 3'd3;
    localparam logic [2:0] ZMIN = 3'd4;
    localparam logic [2:0] ZMAX = 3'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMP_X = 3'd1;
    localparam logic [2:0] ST_CMP_Y = 3'd2;
    localparam logic [2:0] ST_CMP_Z = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;
endpackage

// File: rtl/aabb_overlap_test_if.sv
// Box-pair request and overlap-result handshake bundle (stb/ack on both sides).
interface aabb_overlap_test_if;
    logic [31:0] a0, a1, a2, a3, a4, a5;
    logic [31:0] b0, b1, b2, b3, b4, b5;
    logic        in_stb;
    logic        in_ack;
    logic        overlap;
    logic [1:0]  sep_axis;
    logic        out_stb;
    logic        out_ack;

    modport master (
        output a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5, in_stb, out_ack,
        input  in_ack, overlap, sep_axis, out_stb
    );
    modport slave (
        input  a0, a1, a2, a3, a4, a5, b0, b1, b2, b3, b4, b5, in_stb, out_ack,
        output in_ack, overlap, sep_axis, out_stb
    );
endinterface

// File: rtl/aabb_overlap_test_float_le.sv
// Combinational single-precision p <= q on raw bits; NaN compares false, +0 == -0.
module float_le
    import aabb_pkg::*;
(
    input  logic [FLOAT_W-1:0] p,
    input  logic [FLOAT_W-1:0] q,
    output logic               le
);
    logic p_nan, q_nan, both_zero;

    assign p_nan     = (p[30:23] == FLT_EXP_MAX) && (p[22:0] != '0);
    assign q_nan     = (q[30:23] == FLT_EXP_MAX) && (q[22:0] != '0);
    assign both_zero = (p[30:0] == '0) && (q[30:0] == '0);

    // Sign-magnitude ordering: magnitude compare flips direction for negatives.
    always_comb begin
        le = 1'b0;
        if (p_nan || q_nan)
            le = 1'b0;
        else if (both_zero)
            le = 1'b1;
        else if (p[31] != q[31])
            le = p[31];
        else if (!p[31])
            le = (p[30:0] <= q[30:0]);
        else
            le = (p[30:0] >= q[30:0]);
    end
endmodule

// File: rtl/aabb_overlap_test.sv
// Broadphase AABB pair overlap test: one axis per cycle, reports first separating axis.
module aabb_overlap_test
    import aabb_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic               clk,
    input logic               rst,
    aabb_overlap_test_if.slave bus
);
    logic [2:0] state;
    logic [NUM_BOUNDS-1:0][FLOAT_W-1:0] box_a, box_b;
    logic [1:0] first_fail, new_first, axis_code;
    logic [2:0] lo, hi;
    logic       le_ab, le_ba, axis_ok;
    logic       overlap_q;
    logic [1:0] sep_q;

    assign bus.in_ack   = (state == ST_IDLE);
    assign bus.out_stb  = (state == ST_OUT);
    assign bus.overlap  = overlap_q;
    assign bus.sep_axis = sep_q;

    // Boxes are held for the whole test, so upstream is free after capture.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.in_stb) begin
            box_a <= {bus.a5, bus.a4, bus.a3, bus.a2, bus.a1, bus.a0};
            box_b <= {bus.b5, bus.b4, bus.b3, bus.b2, bus.b1, bus.b0};
        end
    end

    always_comb begin
        lo        = XMIN;
        hi        = XMAX;
        axis_code = AXIS_X;
        case (state)
            ST_CMP_Y: begin lo = YMIN; hi = YMAX; axis_code = AXIS_Y; end
            ST_CMP_Z: begin lo = ZMIN; hi = ZMAX; axis_code = AXIS_Z; end
            default: ;
        endcase
    end

    float_le u_le_ab (.p(box_a[lo]), .q(box_b[hi]), .le(le_ab));
    float_le u_le_ba (.p(box_b[lo]), .q(box_a[hi]), .le(le_ba));

    assign axis_ok   = le_ab && le_ba;
    assign new_first = (first_fail != AXIS_NONE) ? first_fail :
                       (!axis_ok ? axis_code : AXIS_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            overlap_q  <= 1'b0;
            sep_q      <= AXIS_NONE;
            first_fail <= AXIS_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_stb) begin
                        first_fail <= AXIS_NONE;
                        state      <= ST_CMP_X;
                    end
                end
                ST_CMP_X, ST_CMP_Y, ST_CMP_Z: begin
                    if (!axis_ok && EARLY_EXIT) begin
                        overlap_q <= 1'b0;
                        sep_q     <= axis_code;
                        state     <= ST_OUT;
                    end else if (state == ST_CMP_Z) begin
                        overlap_q <= (new_first == AXIS_NONE);
                        sep_q     <= new_first;
                        state     <= ST_OUT;
                    end else begin
                        first_fail <= new_first;
                        state      <= (state == ST_CMP_X) ? ST_CMP_Y : ST_CMP_Z;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ack)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aabb_overlap_test.sv
// Randomized bench for aabb_overlap_test: early-exit and full-latency instances vs a real-valued model.
module tb_aabb_overlap_test;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_stb = 1'b0;
    logic out_ack = 1'b1;
    logic [31:0] ta [6];
    logic [31:0] tbx [6];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    aabb_overlap_test_if bus_e ();
    aabb_overlap_test_if bus_f ();

    aabb_overlap_test #(.EARLY_EXIT(1'b1)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
    aabb_overlap_test #(.EARLY_EXIT(1'b0)) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

    assign bus_e.a0 = ta[0];  assign bus_e.a1 = ta[1];  assign bus_e.a2 = ta[2];
    assign bus_e.a3 = ta[3];  assign bus_e.a4 = ta[4];  assign bus_e.a5 = ta[5];
    assign bus_e.b0 = tbx[0]; assign bus_e.b1 = tbx[1]; assign bus_e.b2 = tbx[2];
    assign bus_e.b3 = tbx[3]; assign bus_e.b4 = tbx[4]; assign bus_e.b5 = tbx[5];
    assign bus_f.a0 = ta[0];  assign bus_f.a1 = ta[1];  assign bus_f.a2 = ta[2];
    assign bus_f.a3 = ta[3];  assign bus_f.a4 = ta[4];  assign bus_f.a5 = ta[5];
    assign bus_f.b0 = tbx[0]; assign bus_f.b1 = tbx[1]; assign bus_f.b2 = tbx[2];
    assign bus_f.b3 = tbx[3]; assign bus_f.b4 = tbx[4]; assign bus_f.b5 = tbx[5];
    assign bus_e.in_stb = in_stb;  assign bus_e.out_ack = out_ack;
    assign bus_f.in_stb = in_stb;  assign bus_f.out_ack = out_ack;

    logic       o_stb [2];
    logic       o_iak [2];
    logic       o_ov  [2];
    logic [1:0] o_sep [2];
    assign o_stb[0] = bus_e.out_stb; assign o_iak[0] = bus_e.in_ack;
    assign o_ov[0]  = bus_e.overlap; assign o_sep[0] = bus_e.sep_axis;
    assign o_stb[1] = bus_f.out_stb; assign o_iak[1] = bus_f.in_ack;
    assign o_ov[1]  = bus_f.overlap; assign o_sep[1] = bus_f.sep_axis;

    // ---------------- reference model: floats as real numbers ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic real f2r(input logic [31:0] x);
        int  e;
        real m, v;
        e = int'(x[30:23]);
        m = real'(x[22:0]);
        if (e == 255)    v = 1.0e300;
        else if (e == 0) v = m * (2.0 ** (-149));
        else             v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
        return x[31] ? -v : v;
    endfunction

    function automatic bit fle(input logic [31:0] p, input logic [31:0] q);
        if (is_nan(p) || is_nan(q)) return 1'b0;
        return f2r(p) <= f2r(q);
    endfunction

    task automatic model(input bit early, output bit ov, output logic [1:0] sep, output int lat);
        sep = 2'd0;
        for (int k = 0; k < 3; k++)
            if (!(fle(ta[2*k], tbx[2*k+1]) && fle(tbx[2*k], ta[2*k+1])) && sep == 2'd0)
                sep = 2'(k + 1);
        ov  = (sep == 2'd0);
        lat = (early && sep != 2'd0) ? int'(sep) : 3;
    endtask

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- transaction tracker: 0 idle, 1 busy, 2 result ----------------
    int         ph   [2];
    int         cnt  [2];
    int         lat_q[2];
    bit         pov  [2];
    bit         cov  [2];
    logic [1:0] psep [2];
    logic [1:0] csep [2];
    int         done [2];
    bit         armed = 1'b0;

    initial for (int d = 0; d < 2; d++) begin ph[d] = 0; done[d] = 0; cov[d] = 0; csep[d] = 0; end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                ph[d] = 0; cov[d] = 1'b0; csep[d] = 2'd0;
            end else begin
                case (ph[d])
                    0: if (in_stb) begin
                        model(d == 0, pov[d], psep[d], lat_q[d]);
                        cnt[d] = 0; ph[d] = 1;
                    end
                    1: begin
                        cnt[d]++;
                        if (cnt[d] == lat_q[d]) begin ph[d] = 2; cov[d] = pov[d]; csep[d] = psep[d]; end
                    end
                    default: if (out_ack) begin ph[d] = 0; done[d]++; end
                endcase
            end
        end
        if (!rst) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                check("out_stb",  d, 32'(o_stb[d]), 32'(ph[d] == 2));
                check("in_ack",   d, 32'(o_iak[d]), 32'(ph[d] == 0));
                check("overlap",  d, 32'(o_ov[d]),  32'(cov[d]));
                check("sep_axis", d, 32'(o_sep[d]), 32'(csep[d]));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        case ($urandom_range(0, 40))
            0: v = 32'h00000000;  1: v = 32'h80000000;  2: v = 32'h3F800000;
            3: v = 32'hBF800000;  4: v = 32'h7F800000;  5: v = 32'hFF800000;
            6: v = 32'h7FC00000;  7: v = 32'h00000001;  8: v = 32'h80000001;
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 130)), 23'($urandom)};
        endcase
        return v;
    endfunction

    task automatic rand_boxes();
        logic [31:0] t;
        for (int i = 0; i < 6; i++) begin ta[i] = rnd_f(); tbx[i] = rnd_f(); end
        for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 7) != 0 && fle(ta[2*k+1], ta[2*k])) begin
                t = ta[2*k]; ta[2*k] = ta[2*k+1]; ta[2*k+1] = t;
            end
            if ($urandom_range(0, 7) != 0 && fle(tbx[2*k+1], tbx[2*k])) begin
                t = tbx[2*k]; tbx[2*k] = tbx[2*k+1]; tbx[2*k+1] = t;
            end
        end
    endtask

    task automatic set_boxes(input logic [31:0] a0, a1, a2, a3, a4, a5,
                             input logic [31:0] b0, b1, b2, b3, b4, b5);
        ta[0] = a0; ta[1] = a1; ta[2] = a2; ta[3] = a3; ta[4] = a4; ta[5] = a5;
        tbx[0] = b0; tbx[1] = b1; tbx[2] = b2; tbx[3] = b3; tbx[4] = b4; tbx[5] = b5;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (!(ph[0] == 0 && ph[1] == 0) && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) begin bad++; total++; $display("FAIL idle_timeout got=busy want=idle"); end
    endtask

    task automatic txn(input bit rand_ack);
        int d0, d1, g;
        wait_idle();
        d0 = done[0]; d1 = done[1];
        in_stb = 1'b1;
        @(negedge clk);
        in_stb = 1'b0;
        for (int i = 0; i < 6; i++) begin ta[i] = $urandom; tbx[i] = $urandom; end
        g = 0;
        while ((done[0] == d0 || done[1] == d1) && g < 100) begin
            out_ack = rand_ack ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk); g++;
        end
        out_ack = 1'b1;
        if (g >= 100) begin bad++; total++; $display("FAIL result_timeout got=none want=result"); end
    endtask

    localparam logic [31:0] F0 = 32'h00000000, F1 = 32'h3F800000, FH = 32'h3F000000;
    localparam logic [31:0] F2 = 32'h40000000, F3 = 32'h40400000;

    initial begin
        bit ov; logic [1:0] sep; int lat;
        set_boxes(F0, F1, F0, F1, F0, F1, FH, F2, FH, F2, FH, F2);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Model pins from hand-computed cases, each then run through both DUTs.
        model(1'b0, ov, sep, lat);
        check("pin_basic_ov", 0, 32'(ov), 32'd1); check("pin_basic_sep", 0, 32'(sep), 32'd0);
        check("pin_basic_lat", 0, 32'(lat), 32'd3);
        txn(1'b0);

        set_boxes(F0, F1, F0, F1, F0, F1, F2, F3, FH, F2, FH, F2);
        model(1'b1, ov, sep, lat);
        check("pin_xsep_ov", 0, 32'(ov), 32'd0); check("pin_xsep_sep", 0, 32'(sep), 32'd1);
        check("pin_xsep_lat_early", 0, 32'(lat), 32'd1);
        model(1'b0, ov, sep, lat);
        check("pin_xsep_lat_full", 1, 32'(lat), 32'd3);
        txn(1'b0);

        set_boxes(F0, F1, 32'hBF800000, 32'h80000000, F0, F1, F1, F2, F0, F1, FH, F2);
        model(1'b1, ov, sep, lat);
        check("pin_touch_ov", 0, 32'(ov), 32'd1); check("pin_touch_sep", 0, 32'(sep), 32'd0);
        txn(1'b0);

        set_boxes(F0, F1, F0, F1, F0, F1, FH, F2, FH, F2, 32'h7FC00000, F2);
        model(1'b1, ov, sep, lat);
        check("pin_nan_ov", 0, 32'(ov), 32'd0); check("pin_nan_sep", 0, 32'(sep), 32'd3);
        txn(1'b0);

        // Backpressure: results parked in OUT while in_stb pulses are offered.
        set_boxes(F0, F1, F0, F1, F0, F1, FH, F2, F2, F3, FH, F2);
        wait_idle();
        out_ack = 1'b0;
        in_stb = 1'b1; @(negedge clk); in_stb = 1'b0;
        for (int i = 0; i < 14; i++) begin
            rand_boxes();
            in_stb = i[0];
            @(negedge clk);
        end
        in_stb = 1'b0;
        check("bp_held_stb_e", 0, 32'(o_stb[0]), 32'd1);
        check("bp_held_stb_f", 1, 32'(o_stb[1]), 32'd1);
        out_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_release_iack", 0, 32'(o_iak[0] & o_iak[1]), 32'd1);

        // Reset while in CMP_Y: nothing may be emitted, then a clean transaction.
        set_boxes(F0, F1, F0, F1, F0, F1, FH, F2, FH, F2, FH, F2);
        wait_idle();
        in_stb = 1'b1; @(negedge clk); in_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rst_iack", 0, 32'(o_iak[0] & o_iak[1]), 32'd1);
        check("rst_stb", 0, 32'(o_stb[0] | o_stb[1]), 32'd0);
        set_boxes(F0, F1, F0, F1, F0, F1, F2, F3, FH, F2, FH, F2);
        txn(1'b0);

        for (int n = 0; n < 250; n++) begin
            rand_boxes();
            txn(1'b1);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
